// File: rtl/wb_result_arbiter.sv
// Round-robin arbiter that funnels eight functional-unit result buses into one
// register-file write-back port through a two-entry output FIFO.
module wb_result_arbiter #(
    parameter int N_SRC  = 8,
    parameter int DATA_W = 32,
    parameter int DEST_W = 5,
    parameter int SRC_W  = $clog2(N_SRC)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [N_SRC-1:0]         src_valid,
    input  logic [N_SRC*DEST_W-1:0]  src_dest,
    input  logic [N_SRC*DATA_W-1:0]  src_data,
    output logic [N_SRC-1:0]         src_ready,
    output logic                     wb_valid,
    input  logic                     wb_ready,
    output logic [DEST_W-1:0]        wb_dest,
    output logic [DATA_W-1:0]        wb_data,
    output logic [SRC_W-1:0]         wb_src
);

    localparam int ENT_W = SRC_W + DEST_W + DATA_W;

    logic [1:0]       count_q, count_d;
    logic [SRC_W-1:0] ptr_q, ptr_d;
    logic [ENT_W-1:0] head_q, head_d;
    logic [ENT_W-1:0] tail_q, tail_d;

    logic             grantFound;
    logic [SRC_W-1:0] grantIdx;
    logic [SRC_W-1:0] probeIdx;
    logic             canAccept;
    logic             push;
    logic             pop;
    logic [ENT_W-1:0] newEntry;

    // Rotating search: N_SRC is a power of two, so the index wraps for free.
    always_comb begin
        grantFound = 1'b0;
        grantIdx   = '0;
        probeIdx   = '0;
        for (int k = 0; k < N_SRC; k++) begin
            probeIdx = ptr_q + SRC_W'(k);
            if (!grantFound && src_valid[probeIdx]) begin
                grantFound = 1'b1;
                grantIdx   = probeIdx;
            end
        end
    end

    assign pop       = (count_q != 2'd0) && wb_ready;
    assign canAccept = (count_q < 2'd2) || pop;
    assign src_ready = (grantFound && canAccept && !flush && reset)
                       ? (N_SRC'(1) << grantIdx) : '0;
    assign push      = |src_ready;
    assign newEntry  = {grantIdx,
                        src_dest[grantIdx*DEST_W +: DEST_W],
                        src_data[grantIdx*DATA_W +: DATA_W]};

    always_comb begin
        count_d = count_q;
        ptr_d   = ptr_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (push) begin
            ptr_d = grantIdx + SRC_W'(1);
        end
        if (flush) begin
            count_d = 2'd0;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_d = newEntry;
                    end else begin
                        tail_d = newEntry;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_d  = tail_q;
                    count_d = count_q - 2'd1;
                end
                // Simultaneous push and pop keeps occupancy; a full FIFO shifts.
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_d = newEntry;
                    end else begin
                        head_d = tail_q;
                        tail_d = newEntry;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= 2'd0;
            ptr_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            ptr_q   <= ptr_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign wb_valid = (count_q != 2'd0);
    assign wb_src   = head_q[ENT_W-1 -: SRC_W];
    assign wb_dest  = head_q[DATA_W +: DEST_W];
    assign wb_data  = head_q[DATA_W-1:0];

endmodule

// File: tb/tb_wb_result_arbiter.sv
// Bench for wb_result_arbiter: directed scenarios then random traffic, checked
// against a queue-based reference model of the arbiter and its output FIFO.
module tb_wb_result_arbiter;

    localparam int N     = 8;
    localparam int DW    = 32;
    localparam int DESTW = 5;
    localparam int SW    = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic [N-1:0]     srcValid;
    logic [N*DESTW-1:0] srcDest;
    logic [N*DW-1:0]  srcData;
    logic [N-1:0]     srcReady;
    logic             wbValid;
    logic             wbReady;
    logic [DESTW-1:0] wbDest;
    logic [DW-1:0]    wbData;
    logic [SW-1:0]    wbSrc;

    int testsRun  = 0;
    int failCount = 0;
    bit dropOnAccept;

    typedef struct {
        int          src;
        int          dest;
        logic [31:0] data;
    } entry_t;

    entry_t mQ[$];
    int     mPtr;

    wb_result_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .src_valid (srcValid),
        .src_dest  (srcDest),
        .src_data  (srcData),
        .src_ready (srcReady),
        .wb_valid  (wbValid),
        .wb_ready  (wbReady),
        .wb_dest   (wbDest),
        .wb_data   (wbData),
        .wb_src    (wbSrc)
    );

    always #5 clk = ~clk;

    function automatic int modelGrant();
        for (int k = 0; k < N; k++) begin
            int i;
            i = (mPtr + k) % N;
            if (srcValid[i]) return i;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expd);
        testsRun++;
        assert (obs === expd) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, expd);
        end
    endtask

    task automatic setSource(input int i, input logic [4:0] d, input logic [31:0] v);
        srcDest[i*DESTW +: DESTW] = d;
        srcData[i*DW +: DW]       = v;
    endtask

    task automatic applyStimulus(input logic [N-1:0] v, input logic r, input logic f);
        srcValid = v;
        wbReady  = r;
        flush    = f;
    endtask

    // One clock: check outputs against the model, then advance the model across the edge.
    task automatic step();
        int           g;
        logic [N-1:0] expReady;
        bit           canAcc;
        entry_t       e;
        #1;
        g        = modelGrant();
        canAcc   = (mQ.size() < 2) || (mQ.size() != 0 && wbReady);
        expReady = '0;
        if (g >= 0 && canAcc && !flush && reset) expReady[g] = 1'b1;
        checkOutput("src_ready", 64'(srcReady), 64'(expReady));
        checkOutput("wb_valid", 64'(wbValid), 64'(mQ.size() != 0));
        if (mQ.size() != 0) begin
            checkOutput("wb_src", 64'(wbSrc), 64'(mQ[0].src));
            checkOutput("wb_dest", 64'(wbDest), 64'(mQ[0].dest));
            checkOutput("wb_data", 64'(wbData), 64'(mQ[0].data));
        end
        if (reset) begin
            if (mQ.size() != 0 && wbReady) void'(mQ.pop_front());
            if (flush) begin
                mQ.delete();
            end else if (expReady != '0) begin
                e.src  = g;
                e.dest = int'(srcDest[g*DESTW +: DESTW]);
                e.data = srcData[g*DW +: DW];
                mQ.push_back(e);
                mPtr = (g + 1) % N;
            end
        end
        @(negedge clk);
        if (dropOnAccept && expReady != '0) srcValid[g] = 1'b0;
    endtask

    initial begin
        reset        = 1'b0;
        dropOnAccept = 1'b0;
        srcDest      = '0;
        srcData      = '0;
        mPtr         = 0;
        applyStimulus(8'hFF, 1'b1, 1'b0);
        for (int i = 0; i < N; i++) setSource(i, 5'(i), 32'hD000_0000 + i);

        // Reset held with every source requesting: nothing granted, outputs zero.
        @(negedge clk);
        step();
        checkOutput("rst_wb_src", 64'(wbSrc), 64'd0);
        checkOutput("rst_wb_dest", 64'(wbDest), 64'd0);
        checkOutput("rst_wb_data", 64'(wbData), 64'd0);
        step();

        // Release: round-robin across all eight sources with wrap.
        reset = 1'b1;
        for (int c = 0; c < 10; c++) step();

        // Drain, then backpressure with sources 2 and 5.
        applyStimulus(8'h00, 1'b1, 1'b0);
        step();
        step();
        dropOnAccept = 1'b1;
        setSource(2, 5'd3, 32'hAAAA_0002);
        setSource(5, 5'd9, 32'hAAAA_0005);
        applyStimulus(8'h24, 1'b0, 1'b0);
        step();
        step();
        setSource(4, 5'd17, 32'hAAAA_0004);
        applyStimulus(8'h10, 1'b0, 1'b0);
        step();
        step();
        wbReady = 1'b1;
        for (int c = 0; c < 4; c++) step();

        // Flush with FIFO full and source 1 waiting.
        setSource(0, 5'd1, 32'h1111_0000);
        setSource(3, 5'd2, 32'h3333_0000);
        setSource(1, 5'd7, 32'h5555_0001);
        applyStimulus(8'h09, 1'b0, 1'b0);
        step();
        step();
        applyStimulus(8'h02, 1'b0, 1'b1);
        step();
        flush = 1'b0;
        step();
        wbReady = 1'b1;
        step();
        step();

        // Sparse fairness between sources 6 and 7.
        dropOnAccept = 1'b0;
        applyStimulus(8'h40, 1'b1, 1'b0);
        step();
        srcValid = 8'hC0;
        for (int c = 0; c < 4; c++) step();

        // Asynchronous reset in the middle of a full FIFO.
        applyStimulus(8'h48, 1'b0, 1'b0);
        step();
        step();
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_wb_valid", 64'(wbValid), 64'd0);
        checkOutput("async_wb_data", 64'(wbData), 64'd0);
        checkOutput("async_wb_src", 64'(wbSrc), 64'd0);
        checkOutput("async_src_ready", 64'(srcReady), 64'd0);
        mQ.delete();
        mPtr = 0;
        @(negedge clk);
        reset   = 1'b1;
        wbReady = 1'b1;
        for (int c = 0; c < 4; c++) step();

        // Random traffic with sources holding results until accepted.
        dropOnAccept = 1'b1;
        srcValid     = '0;
        repeat (400) begin
            for (int i = 0; i < N; i++) begin
                if (!srcValid[i] && $urandom_range(0, 3) == 0) begin
                    srcValid[i] = 1'b1;
                    setSource(i, 5'($urandom), $urandom);
                end
            end
            wbReady = ($urandom_range(0, 9) < 7);
            flush   = ($urandom_range(0, 19) == 0);
            step();
        end
        flush = 1'b0;

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
